// File: rtl/quality_pkg.sv
// Shared grade codes, diverter bin encodings and sorter state type.
// Used by quality_grade_decode and quality_sorter.
package quality_pkg;

  localparam logic [2:0] GRADE_F1  = 3'b100;
  localparam logic [2:0] GRADE_F2  = 3'b010;
  localparam logic [2:0] GRADE_F3  = 3'b001;
  localparam logic [2:0] GRADE_REJ = 3'b000;

  localparam logic [1:0] BIN_REJ = 2'd0;
  localparam logic [1:0] BIN_F1  = 2'd1;
  localparam logic [1:0] BIN_F2  = 2'd2;
  localparam logic [1:0] BIN_F3  = 2'd3;

  typedef enum logic [1:0] {
    QS_IDLE    = 2'd0,
    QS_ACTUATE = 2'd1,
    QS_SETTLE  = 2'd2
  } qs_state_t;

endpackage

// File: rtl/quality_grade_decode.sv
// Combinational grade -> bin map; multi-hot handling selected by QS_ILLEGAL_CHECK_EN.
// Zero latency, no flow control.
module quality_grade_decode
  import quality_pkg::*;
(
  input  logic [2:0] grade_i,
  output logic [1:0] bin_o,
  output logic       illegal_o
);

  always_comb begin
    bin_o     = BIN_REJ;
    illegal_o = 1'b0;
    case (grade_i)
      GRADE_F1:  bin_o = BIN_F1;
      GRADE_F2:  bin_o = BIN_F2;
      GRADE_F3:  bin_o = BIN_F3;
      GRADE_REJ: bin_o = BIN_REJ;
      default: begin
`ifdef QS_ILLEGAL_CHECK_EN
        bin_o     = BIN_REJ;
        illegal_o = 1'b1;
`else
        // Multi-hot: the highest class flag wins.
        if (grade_i[2])      bin_o = BIN_F1;
        else if (grade_i[1]) bin_o = BIN_F2;
        else                 bin_o = BIN_F3;
`endif
      end
    endcase
  end

endmodule

// File: rtl/quality_sorter.sv
// Grade sorter: decode, gate hold FSM, saturating per-bin tallies (QS_ILLEGAL_CHECK_EN gates err).
// bin_sel/tally from N+1, gate_en N+1..N+GATE_CYC; grade_ready low while busy, busy inputs ignored.
module quality_sorter
  import quality_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int GATE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             grade_valid,
  input  logic [2:0]       grade,
  output logic             grade_ready,
  output logic [1:0]       bin_sel,
  output logic             gate_en,
  output logic [CNT_W-1:0] cnt_f1,
  output logic [CNT_W-1:0] cnt_f2,
  output logic [CNT_W-1:0] cnt_f3,
  output logic [CNT_W-1:0] cnt_rej,
  output logic             err
);

  localparam logic [7:0] HOLD_INIT = 8'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  qs_state_t        state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [1:0]       bin_q, bin_d;
  logic             gate_q, gate_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  logic [1:0] dec_bin;
  logic       dec_illegal;
  logic       accept;

  quality_grade_decode u_decode (
    .grade_i   (grade),
    .bin_o     (dec_bin),
    .illegal_o (dec_illegal)
  );

  assign grade_ready = (state_q == QS_IDLE);
  assign accept      = grade_valid && grade_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    bin_d   = bin_q;
    gate_d  = gate_q;
    err_d   = err_q;
    case (state_q)
      QS_IDLE: begin
        if (accept) begin
          bin_d   = dec_bin;
          hold_d  = HOLD_INIT;
          gate_d  = 1'b1;
          state_d = QS_ACTUATE;
          if (dec_illegal) err_d = 1'b1;
        end
      end
      QS_ACTUATE: begin
        if (hold_q == 8'd0) begin
          gate_d  = 1'b0;
          state_d = QS_SETTLE;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      QS_SETTLE: state_d = QS_IDLE;
      default: begin
        gate_d  = 1'b0;
        state_d = QS_IDLE;
      end
    endcase
  end

  // Only the decoded bin moves, and only on an accept edge.
  always_comb begin
    for (int b = 0; b < 4; b++) cnt_d[b] = cnt_q[b];
    if (accept && (cnt_q[dec_bin] != CNT_MAX))
      cnt_d[dec_bin] = cnt_q[dec_bin] + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= QS_IDLE;
      hold_q  <= 8'd0;
      bin_q   <= BIN_REJ;
      gate_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int b = 0; b < 4; b++) cnt_q[b] <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      bin_q   <= bin_d;
      gate_q  <= gate_d;
      err_q   <= err_d;
      for (int b = 0; b < 4; b++) cnt_q[b] <= cnt_d[b];
    end
  end

  assign bin_sel = bin_q;
  assign gate_en = gate_q;
  assign err     = err_q;
  assign cnt_rej = cnt_q[BIN_REJ];
  assign cnt_f1  = cnt_q[BIN_F1];
  assign cnt_f2  = cnt_q[BIN_F2];
  assign cnt_f3  = cnt_q[BIN_F3];

endmodule

// File: doc/quality_sorter.md
# quality_sorter

Sequential consumer of the three-flag quality grade word {F1,F2,F3} produced by the upstream grading logic. It accepts one graded item per valid/ready handshake and decodes the grade into a sort bin. It holds the sorting gate actuator for a fixed number of cycles and keeps a saturating per-bin tally for the line supervisor. It sits between the grading stage and the mechanical diverter on the inspection line.

## Interface
Parameters:
- CNT_W, 8: width of each tally counter.
- GATE_CYC, 4: cycles gate_en stays asserted per item; legal range 1..255.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- grade_valid  input  1  upstream presents a grade.
- grade  input  3  {F1,F2,F3}: 100 = first class, 010 = second class, 001 = third class, 000 = reject.
- grade_ready  output  1  block can accept a grade this cycle.
- bin_sel  output  2  diverter target: 0 = reject, 1 = first, 2 = second, 3 = third.
- gate_en  output  1  diverter actuator drive.
- cnt_f1, cnt_f2, cnt_f3, cnt_rej  output  CNT_W each  tally per bin.
- err  output  1  sticky flag: an illegal grade code was received.

## Operation
- FSM states are IDLE, ACTUATE and SETTLE.
- IDLE:
  - grade_ready=1.
  - Accept when grade_valid && grade_ready.
  - On accept, latch the decoded bin into bin_sel, load the hold counter with GATE_CYC-1, and go to ACTUATE.
- ACTUATE:
  - gate_en=1, grade_ready=0, bin_sel held.
  - The hold counter decrements each cycle. When it reaches 0, go to SETTLE.
- SETTLE:
  - gate_en=0, grade_ready=0, bin_sel held.
  - Lasts exactly one cycle, then returns to IDLE.
- Decode:
  - 100→1, 010→2, 001→3, 000→0.
  - Any other code (multi-hot) is handled per Configuration.
- Tally:
  - The counter of the decoded bin increments at the accept edge.
  - Each counter saturates at 2^CNT_W−1 and never wraps.
  - Only one counter changes per accept.
- grade_valid while grade_ready=0 is ignored. The upstream must hold its data; the block never samples a grade outside IDLE.
- Reset values: state IDLE, grade_ready=1, gate_en=0, bin_sel=0, all counters 0, err=0.
- Reset asserted mid-ACTUATE: gate_en drops immediately (asynchronously) and the in-flight item is abandoned; its tally increment is already committed.

## Timing
- Accept at edge N. Counter and bin_sel are visible from cycle N+1.
- gate_en is high for cycles N+1 … N+GATE_CYC.
- SETTLE is cycle N+GATE_CYC+1.
- grade_ready returns high in cycle N+GATE_CYC+2.
- Maximum throughput is one item per GATE_CYC+2 cycles.
- gate_en and bin_sel are registered outputs with no combinational path from the inputs.
- grade_ready is a pure function of state.

## Configuration
- QS_ILLEGAL_CHECK_EN defined:
  - A multi-hot grade is routed to bin 0 and counted in cnt_rej.
  - err sets at the accept edge and stays set until reset.
- QS_ILLEGAL_CHECK_EN undefined:
  - Multi-hot codes use priority decode: F1 over F2 over F3.
  - err is tied to 0.

## Structure
- Package quality_pkg holds:
  - grade code constants GRADE_F1/F2/F3/REJ;
  - bin encodings BIN_REJ/F1/F2/F3;
  - the state enum qs_state_t.
- One sub-module is natural: quality_grade_decode, a combinational map grade → {bin, illegal}. The macro applies inside it.
- FSM, hold counter and tallies live in quality_sorter.

## Test plan
- Reset then idle:
  - all outputs at their reset values;
  - grade_ready=1 continuously with grade_valid=0.
- grade=100 accepted at edge N, GATE_CYC=4:
  - cnt_f1=1 and bin_sel=1 from N+1;
  - gate_en high N+1..N+4, low N+5;
  - grade_ready high at N+6.
- Back-to-back grades 010, 001, 000 with grade_valid held high:
  - accepts spaced exactly 6 cycles apart;
  - cnt_f2=cnt_f3=cnt_rej=1;
  - inputs presented while busy are not counted.
- grade=110:
  - with the macro: bin_sel=0, cnt_rej+1, err=1 and stays 1;
  - without the macro: bin_sel=1, cnt_f1+1, err=0.
- CNT_W=2, five 100 grades → cnt_f1 saturates at 3.
- rst_n pulsed low in the 2nd ACTUATE cycle:
  - gate_en=0 immediately, all counters 0, state IDLE;
  - the next grade is accepted normally.
